lsu: RTL

LSU -- requirements
Module: lsu

---
 rtl/lsu_pkg.sv | 54 +++++
 rtl/lsu_if.sv | 39 +++
 rtl/lsu_align.sv | 71 +++++++
 rtl/lsu.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the core: ALU and load/store funct3 codes, the
// byte-enable width, the LSU state type and a funct3 legality helper.
//
// Contents
//   DATA_W, BE_W        data/address width and byte-lane count
//   F3_*                ALU and load/store funct3 encodings
//   lsu_state_e         LSU controller states
//   f3_legal()          is a funct3 a supported load/store encoding
//
// Configuration macro: LSU_MISALIGN_TRAP_EN (consumed in lsu.sv)
// ---------------------------------------------------------------------------
package lsu_pkg;

   localparam int DATA_W = 32;
   localparam int BE_W   = DATA_W / 8;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SRL  = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } lsu_state_e;

   // Stores have no unsigned variants, so the legal set differs by direction.
   function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
      logic ok;
      if (is_store)
         ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
      else
         ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
              (f3 == F3_LBU) || (f3 == F3_LHU);
      return ok;
   endfunction

endpackage

// File: rtl/lsu_if.sv
// ---------------------------------------------------------------------------
// lsu_if
// Single-cycle-acknowledge memory bus between the LSU (master) and memory
// (slave).
//
// Signals
//   mem_req_o    request, held until the acknowledge cycle
//   mem_we_o     write enable
//   mem_addr_o   word address, bits[1:0] always zero
//   mem_be_o     byte-lane enables
//   mem_wdata_o  lane-replicated store data
//   mem_rdata_i  read data, valid in the acknowledge cycle
//   mem_ack_i    acknowledge, one cycle
// ---------------------------------------------------------------------------
interface lsu_if
   import lsu_pkg::*;
#(
   parameter int SIZE = DATA_W
);

   logic            mem_req_o;
   logic            mem_we_o;
   logic [SIZE-1:0] mem_addr_o;
   logic [BE_W-1:0] mem_be_o;
   logic [SIZE-1:0] mem_wdata_o;
   logic [SIZE-1:0] mem_rdata_i;
   logic            mem_ack_i;

   modport master (
      output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
      input  mem_rdata_i, mem_ack_i
   );

   modport slave (
      input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
      output mem_rdata_i, mem_ack_i
   );

endinterface

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align
// Combinational lane steering for the LSU: byte enables and replicated data
// for stores, lane selection plus sign/zero extension for loads.
//
// Ports
//   f3         funct3 of the access
//   offset     address bits[1:0]
//   wdata      raw store data (rs2)
//   rdata      raw bus read word
//   be         byte-lane enables for the bus
//   wdata_lane store data replicated across lanes
//   rdata_ext  aligned and extended load result
// ---------------------------------------------------------------------------
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]        f3,
   input  logic [1:0]        offset,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] rdata,
   output logic [BE_W-1:0]   be,
   output logic [DATA_W-1:0] wdata_lane,
   output logic [DATA_W-1:0] rdata_ext
);

   logic [7:0]  load_byte;
   logic [15:0] load_half;

   // Store side: size comes from f3[1:0]. Halves only look at offset[1], so
   // a misaligned half silently lands on its natural boundary; words always
   // enable every lane.
   always_comb begin
      be         = 4'b1111;
      wdata_lane = wdata;
      case (f3[1:0])
         2'b00: begin
            be         = 4'b0001 << offset;
            wdata_lane = {4{wdata[7:0]}};
         end
         2'b01: begin
            be         = 4'b0011 << {offset[1], 1'b0};
            wdata_lane = {2{wdata[15:0]}};
         end
         default: begin
            be         = 4'b1111;
            wdata_lane = wdata;
         end
      endcase
   end

   // Load side: pick the addressed lane, then extend. f3[2] marks the
   // unsigned variants.
   always_comb begin
      load_byte = rdata[7:0];
      case (offset)
         2'd0:    load_byte = rdata[7:0];
         2'd1:    load_byte = rdata[15:8];
         2'd2:    load_byte = rdata[23:16];
         default: load_byte = rdata[31:24];
      endcase
      load_half = offset[1] ? rdata[31:16] : rdata[15:0];
      rdata_ext = rdata;
      case (f3[1:0])
         2'b00:   rdata_ext = {{24{load_byte[7] & ~f3[2]}}, load_byte};
         2'b01:   rdata_ext = {{16{load_half[15] & ~f3[2]}}, load_half};
         default: rdata_ext = rdata;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// ---------------------------------------------------------------------------
// lsu
// Load/store unit: captures one access request, runs it over the memory bus
// and returns an aligned, extended load result or an error pulse.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   start_i       one-cycle request, sampled only when idle
//   is_store_i    1 = store, 0 = load
//   f3_i          funct3 of the access
//   addr_i        effective address
//   wdata_i       store data
//   busy_o        high whenever not idle
//   done_o        one-cycle completion pulse
//   err_o         access rejected (valid with done_o)
//   rdata_o       last load result, held until the next load completes
//   bus           memory bus (lsu_if master)
//
// Configuration
//   LSU_MISALIGN_TRAP_EN  defined: misaligned half/word accesses are rejected
//                         without a bus cycle. Undefined: they are issued
//                         with the low address bits dropped.
// ---------------------------------------------------------------------------
module lsu
   import lsu_pkg::*;
#(
   parameter int SIZE = 32
)
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic            is_store_i,
   input  logic [2:0]      f3_i,
   input  logic [SIZE-1:0] addr_i,
   input  logic [SIZE-1:0] wdata_i,
   output logic            busy_o,
   output logic            done_o,
   output logic            err_o,
   output logic [SIZE-1:0] rdata_o,
   lsu_if.master           bus
);

   lsu_state_e      state;
   logic            is_store_q;
   logic [2:0]      f3_q;
   logic [SIZE-1:0] addr_q;
   logic [SIZE-1:0] wdata_q;
   logic            req;
   logic            busy;
   logic            done;
   logic            err;
   logic [SIZE-1:0] rdata;

   logic            misaligned;
   logic            accept;
   logic [BE_W-1:0] be_lane;
   logic [SIZE-1:0] wdata_lane;
   logic [SIZE-1:0] load_data;

   // Misalignment only matters when trapping is built in; otherwise the
   // align block truncates the offset for us.
`ifdef LSU_MISALIGN_TRAP_EN
   assign misaligned = ((f3_i[1:0] == 2'b01) && addr_i[0]) ||
                       ((f3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
`else
   assign misaligned = 1'b0;
`endif

   assign accept = f3_legal(is_store_i, f3_i) && !misaligned;

   // Lane steering always works from the captured request so the bus stays
   // stable for the whole request phase regardless of the input pins.
   lsu_align u_align (
      .f3         (f3_q),
      .offset     (addr_q[1:0]),
      .wdata      (wdata_q),
      .rdata      (bus.mem_rdata_i),
      .be         (be_lane),
      .wdata_lane (wdata_lane),
      .rdata_ext  (load_data)
   );

   // Controller: capture on start, issue the bus cycle for legal accesses,
   // skip straight to DONE with an error for rejected ones. All outputs are
   // registered here; reset drops the request immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         is_store_q <= 1'b0;
         f3_q       <= 3'b000;
         addr_q     <= '0;
         wdata_q    <= '0;
         req        <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         rdata      <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_i) begin
                  is_store_q <= is_store_i;
                  f3_q       <= f3_i;
                  addr_q     <= addr_i;
                  wdata_q    <= wdata_i;
                  busy       <= 1'b1;
                  if (accept) begin
                     state <= ST_REQ;
                     req   <= 1'b1;
                  end else begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                     err   <= 1'b1;
                  end
               end
            end
            ST_REQ: begin
               if (bus.mem_ack_i) begin
                  state <= ST_DONE;
                  req   <= 1'b0;
                  done  <= 1'b1;
                  err   <= 1'b0;
                  if (!is_store_q)
                     rdata <= load_data;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               done  <= 1'b0;
               err   <= 1'b0;
               busy  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               req   <= 1'b0;
               done  <= 1'b0;
               err   <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Bus fields are qualified by the request so nothing leaks onto the bus
   // outside a request phase.
   assign bus.mem_req_o   = req;
   assign bus.mem_we_o    = req & is_store_q;
   assign bus.mem_addr_o  = req ? {addr_q[SIZE-1:2], 2'b00} : '0;
   assign bus.mem_be_o    = req ? be_lane : '0;
   assign bus.mem_wdata_o = req ? wdata_lane : '0;

   assign busy_o  = busy;
   assign done_o  = done;
   assign err_o   = err;
   assign rdata_o = rdata;

endmodule
